// File: rtl/simd_pkg.sv
// Shared SIMD definitions: instruction geometry, opcode encoding and the
// instruction-loader state encoding.
package simd_pkg;

  localparam int DEF_INS_ADDR_WIDTH = 10;
  localparam int DEF_ADDR_WIDTH     = 10;
  localparam int DEF_OPCODE_WIDTH   = 3;

  // Instruction word is opcode | a | b | r.
  function automatic int ins_width(input int opcode_w, input int addr_w);
    return opcode_w + 3 * addr_w;
  endfunction

  // Whole bytes needed to carry one instruction on the byte link.
  function automatic int bytes_per_ins(input int ins_w);
    return (ins_w + 7) / 8;
  endfunction

  localparam int INS_WIDTH     = ins_width(DEF_OPCODE_WIDTH, DEF_ADDR_WIDTH);
  localparam int BYTES_PER_INS = bytes_per_ins(INS_WIDTH);

  typedef enum logic [2:0] {
    ADD       = 3'd0,
    SUB       = 3'd1,
    MUL       = 3'd2,
    DOT_SHIFT = 3'd3,
    DOT_ACC   = 3'd4,
    PASS_B    = 3'd5
  } opcode_e;

  typedef enum logic [2:0] {
    ST_HDR_HI = 3'd0,
    ST_HDR_LO = 3'd1,
    ST_LOAD   = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERROR  = 3'd4
  } ld_state_e;

endpackage

// File: rtl/byte_packer.sv
// Assembles NBYTES consecutive stream bytes (MSB first) into one word.
// word_o already includes the byte presented this cycle, so it is the
// complete word whenever word_valid_o is high.
module byte_packer
  import simd_pkg::*;
#(
  parameter int NBYTES = BYTES_PER_INS
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clr_i,
  input  logic                  byte_en_i,
  input  logic [7:0]            byte_i,
  output logic                  word_valid_o,
  output logic [NBYTES*8-1:0]   word_o
);

  localparam int WW = NBYTES * 8;
  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  logic [WW-1:0] shreg_q, shreg_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign shreg_d      = (shreg_q << 8) | WW'(byte_i);
  assign word_o       = shreg_d;
  assign word_valid_o = byte_en_i && (cnt_q == LAST);

  // Byte counter: restarts when the loader is outside LOAD, wraps on the last byte.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (byte_en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  // Shift register and counter state.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (byte_en_i) begin
        shreg_q <= shreg_d;
      end
    end
  end

endmodule

// File: rtl/ins_loader.sv
// Streams a program from a byte link into the instruction memory and holds
// the core in reset until the whole program is written.
// Stream: 2-byte instruction count N (MSB first), then N instructions of
// BYTES_PER_INS bytes each, MSB first, word right-aligned in the bytes.
// Handshake: a byte moves only on a cycle where s_valid && s_ready; s_ready
// is registered and does not depend on s_valid.
// Optional build macro INS_LOADER_OPCODE_CHECK_EN: reject words with an
// opcode above PASS_B or nonzero pad bits by entering ERROR instead of writing.
module ins_loader
  import simd_pkg::*;
#(
  parameter int INS_ADDR_WIDTH = DEF_INS_ADDR_WIDTH,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int OPCODE_WIDTH   = DEF_OPCODE_WIDTH
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                start,
  input  logic [7:0]                          s_data,
  input  logic                                s_valid,
  output logic                                s_ready,
  output logic                                ins_wr_en,
  output logic [INS_ADDR_WIDTH-1:0]           ins_wr_addr,
  output logic [OPCODE_WIDTH+3*ADDR_WIDTH-1:0] ins_wr_data,
  output logic                                proc_rstn,
  output logic                                done,
  output logic                                error,
  output ld_state_e                           dbg_state
);

  localparam int IW  = OPCODE_WIDTH + 3 * ADDR_WIDTH;
  localparam int BPI = (IW + 7) / 8;
  localparam int PW  = BPI * 8;
  localparam logic [16:0] DEPTH = 17'(1 << INS_ADDR_WIDTH);

  ld_state_e                 state_q, state_d;
  logic [15:0]               n_q, n_d;
  logic [INS_ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                      wr_en_q, wr_en_d;
  logic [INS_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [IW-1:0]             wr_data_q, wr_data_d;
  logic                      s_ready_q, s_ready_d;
  logic                      done_q, done_d;
  logic                      error_q, error_d;

  logic          accept;
  logic [15:0]   hdr_n;
  logic          pk_valid;
  logic [PW-1:0] pk_word;
  logic          word_ok;
  logic          last_ins;

  assign accept   = s_valid && s_ready_q;
  assign hdr_n    = {n_q[15:8], s_data};
  assign last_ins = (17'(idx_q) + 17'd1) == {1'b0, n_q};

  byte_packer #(.NBYTES(BPI)) u_packer (
    .clk          (clk),
    .rstn         (rstn),
    .clr_i        (state_q != ST_LOAD),
    .byte_en_i    (accept && (state_q == ST_LOAD)),
    .byte_i       (s_data),
    .word_valid_o (pk_valid),
    .word_o       (pk_word)
  );

`ifdef INS_LOADER_OPCODE_CHECK_EN
  logic [OPCODE_WIDTH-1:0] pk_opcode;
  logic                    pk_pad_nz;
  assign pk_opcode = pk_word[IW-1 -: OPCODE_WIDTH];
  assign pk_pad_nz = |(pk_word >> IW);
  assign word_ok   = !pk_pad_nz && (32'(pk_opcode) <= 32'(PASS_B));
`else
  logic unused_pad_bits;
  assign unused_pad_bits = |(pk_word >> IW);
  assign word_ok         = 1'b1;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_HDR_HI;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: header decode, load completion/abort, re-arm on start.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_HDR_HI: if (accept) state_d = ST_HDR_LO;
      ST_HDR_LO: begin
        if (accept) begin
          if (hdr_n == 16'd0)              state_d = ST_DONE;
          else if ({1'b0, hdr_n} > DEPTH)  state_d = ST_ERROR;
          else                             state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (pk_valid) begin
          if (!word_ok)      state_d = ST_ERROR;
          else if (last_ins) state_d = ST_DONE;
        end
      end
      ST_DONE, ST_ERROR: if (start) state_d = ST_HDR_HI;
      default: state_d = ST_HDR_HI;
    endcase
  end

  // FSM outputs and datapath next values. done waits one extra cycle when
  // coming from LOAD so the last write lands before the core is released.
  always_comb begin
    n_d       = n_q;
    idx_d     = idx_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    unique case (state_q)
      ST_HDR_HI: if (accept) n_d = {s_data, n_q[7:0]};
      ST_HDR_LO: begin
        if (accept) begin
          n_d   = hdr_n;
          idx_d = '0;
        end
      end
      ST_LOAD: begin
        if (pk_valid && word_ok) begin
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q;
          wr_data_d = pk_word[IW-1:0];
          idx_d     = idx_q + INS_ADDR_WIDTH'(1);
        end
      end
      default: ;
    endcase
    s_ready_d = (state_d != ST_DONE);
    done_d    = (state_d == ST_DONE) && (state_q != ST_LOAD);
    error_d   = (state_d == ST_ERROR);
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      n_q       <= '0;
      idx_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      s_ready_q <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      n_q       <= n_d;
      idx_q     <= idx_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      s_ready_q <= s_ready_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign s_ready     = s_ready_q;
  assign ins_wr_en   = wr_en_q;
  assign ins_wr_addr = wr_addr_q;
  assign ins_wr_data = wr_data_q;
  assign done        = done_q;
  assign proc_rstn   = done_q;
  assign error       = error_q;
  assign dbg_state   = state_q;

endmodule

// File: doc/ins_loader.md
# ins_loader

Streams a program into the SIMD instruction memory, writing the words the decoder fetches. It receives a byte stream over a valid/ready handshake and assembles it into `OPCODE_WIDTH+3*ADDR_WIDTH`-bit instructions. It writes them sequentially from address 0 and holds the processor core in reset until the whole program is written. It sits between the host byte link (UART/JTAG bridge) and the instruction BRAM write port.

## Interface
- `INS_ADDR_WIDTH`, 10: instruction memory address width; depth is `2**INS_ADDR_WIDTH`.
- `ADDR_WIDTH`, 10: data-memory operand field width.
- `OPCODE_WIDTH`, 3: opcode field width.
- `clk` in 1: clock.
- `rstn` in 1: reset, synchronous, active-low.
- `start` in 1: single-cycle pulse that re-arms the loader from DONE or ERROR.
- `s_data` in 8: stream byte.
- `s_valid` in 1: byte valid.
- `s_ready` out 1: loader accepts a byte.
- `ins_wr_en` out 1: instruction memory write strobe.
- `ins_wr_addr` out INS_ADDR_WIDTH: write address.
- `ins_wr_data` out `OPCODE_WIDTH+3*ADDR_WIDTH`: instruction word, laid out as opcode | a | b | r from MSB to LSB.
- `proc_rstn` out 1: core reset, active-low; drives the decoder/PE `rstn`.
- `done` out 1: program loaded.
- `error` out 1: load aborted.

## Operation
- **Stream format**
  - 2-byte header carrying the instruction count N, MSB first.
  - N instructions follow, each `BYTES_PER_INS = ceil(INS_WIDTH/8)` bytes (5 at defaults), MSB first.
  - The word is right-aligned in the bytes; upper pad bits are ignored.
- **States:** HDR_HI, HDR_LO, LOAD, DONE, ERROR.
- **HDR_HI:** latch `N[15:8]`, then go to HDR_LO.
- **HDR_LO:** latch `N[7:0]`.
  - N = 0: go to DONE.
  - N > `2**INS_ADDR_WIDTH`: go to ERROR.
  - Otherwise: go to LOAD with index 0 and byte counter 0.
- **LOAD:**
  - Each accepted byte shifts into the packer and increments the byte counter.
  - On the `BYTES_PER_INS`-th byte, the counter wraps to 0 and a write is issued at the current index; the index then increments.
  - After write N−1, go to DONE.
- **DONE:** hold `s_ready`=0. `start` returns to HDR_HI, clears `done` and drives `proc_rstn`=0.
- **ERROR:** `s_ready`=1 so the link drains; bytes are discarded. `start` returns to HDR_HI and clears `error`.
- A byte is accepted only when `s_valid && s_ready`. Bytes arriving with `s_ready`=0 are not consumed.
- `start` while in HDR_HI, HDR_LO or LOAD is ignored.

## Timing
- **Reset values:**
  - State HDR_HI.
  - `s_ready`=0 during reset, 1 from the first cycle after reset.
  - `ins_wr_en`=0, `ins_wr_addr`=0, `ins_wr_data`=0.
  - `proc_rstn`=0, `done`=0, `error`=0.
- **Write latency:** if the last byte of an instruction is accepted in cycle t, then in cycle t+1 `ins_wr_en`=1 for exactly one cycle, with address and data valid.
- **No backpressure:** `s_ready` stays 1 throughout LOAD, so one byte per cycle is sustained.
- **Release:**
  - After the final write at t+1: `done`=1 and `proc_rstn`=1 at t+2, so the decoder PC starts at 0.
  - With N = 0: `done` and `proc_rstn` rise one cycle after the header's low byte is accepted.
- **Error:** `error` rises one cycle after the offending byte is accepted. `proc_rstn` stays 0.
- **Mid-load reset:** `rstn` low mid-load aborts immediately; all outputs return to reset values. Partially written memory is not cleared.
- **`start` from DONE:** `proc_rstn` falls in the cycle after `start`. `s_ready`=1 from that same cycle.

## Configuration
- **`INS_LOADER_OPCODE_CHECK_EN` defined:**
  - A completed instruction whose opcode is above PASSB (3'b101), or whose pad bits are nonzero, is not written.
  - Instead, ERROR is entered and `error` rises at t+1.
- **Undefined:** every word is written unchecked. Undefined opcodes execute as NOP in the decoder.

## Structure
- **Shared package `simd_pkg`:**
  - `INS_WIDTH` and `BYTES_PER_INS` localparams.
  - Opcode enum: ADD=0, SUB=1, MUL=2, DOT_SHIFT=3, DOT_ACC=4, PASS_B=5.
  - Loader state enum.
- **Sub-module `byte_packer`:**
  - Shift register of `BYTES_PER_INS*8` bits with a byte counter.
  - Asserts `word_valid` on the final byte.
- The loader FSM, index counter and write register stay in `ins_loader`.

## Test plan
- Header 00 01, then 00 00 10 08 03 back-to-back → one write: addr 0, data 0x0_0010_0803 (ADD a=1 b=2 r=3). `done`/`proc_rstn` rise 2 cycles after the last byte.
- Header 00 02, then MUL 00 80 10 08 03 and DOT_SHIFT 00 C0 10 08 03, with `s_valid` toggling every other cycle → writes at addr 0 = 0x0_8010_0803 and addr 1 = 0x0_C010_0803. Exactly 2 write strobes.
- Header 00 00 → no writes; `done`=1 one cycle later.
- Header 04 01 (N=1025 > 1024) → `error`=1 and `proc_rstn`=0. Following bytes are accepted and dropped.
- Opcode check (macro defined): header 00 01, bytes 01 C0 00 00 00 (opcode 7) → no write and `error`=1. Same stream with macro undefined → write 0x1_C000_0000 and `done`=1.
- `rstn` low after byte 3 of instruction 2, then `start` after a later full load → outputs at reset values during abort. The reload starts again at addr 0, and `proc_rstn` drops the cycle after `start` from DONE.
